// File: rtl/pong_pkg.sv
// -----------------------------------------------------------------------------
// pong_pkg
// Shared definitions for the Pingpong game controller.
//   state_e  : game state encoding, also the value driven on pong_game_ctrl.state
//   SCORE_W  : width of each player's score
//   sat_inc  : score increment that stops at a limit instead of wrapping
// -----------------------------------------------------------------------------
package pong_pkg;

  localparam int SCORE_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_PAUSE = 3'd3,
    ST_POINT = 3'd4,
    ST_OVER  = 3'd5
  } state_e;

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s,
                                                  input logic [SCORE_W-1:0] lim);
    logic [SCORE_W-1:0] r;
    r = (s >= lim) ? lim : s + 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/pong_frame_counter.sv
// -----------------------------------------------------------------------------
// pong_frame_counter
// 8-bit frame counter used for the serve delay.
//   clk   in  pixel clock
//   rst   in  synchronous active-low reset (count -> 0)
//   i_clr in  synchronous clear, wins over i_en
//   i_en  in  count enable (one frame_tick per frame)
//   o_tc  out terminal count: current count equals TERMINAL
// -----------------------------------------------------------------------------
module pong_frame_counter #(
  parameter logic [7:0] TERMINAL = 8'd59
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  logic [7:0] r_count;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_count <= 8'd0;
    end else if (i_clr) begin
      r_count <= 8'd0;
    end else if (i_en) begin
      r_count <= r_count + 8'd1;
    end
  end

  assign o_tc = (r_count == TERMINAL);

endmodule

// File: rtl/pong_game_ctrl.sv
// -----------------------------------------------------------------------------
// pong_game_ctrl
// Game-sequencing FSM for Pingpong. Gates ball motion to one step per frame,
// runs the serve delay, scoring, pause and game-over, and exposes state/score.
//   clk         in  pixel clock, rising edge
//   rst         in  synchronous active-low reset
//   frame_tick  in  one-cycle pulse per frame
//   key_pulse   in  [4:0] debounced key pulses (KEY_START / KEY_PAUSE bits)
//   hit_l/hit_r in  ball touched left/right paddle (sampled on frame_tick)
//   miss_l/r    in  ball passed left/right goal line (sampled on frame_tick)
//   ball_step   out strobe: advance ball one step
//   ball_load   out strobe: recentre ball, load serve_dir
//   bounce_x    out strobe with ball_step: negate x-velocity
//   serve_dir   out 0 = serve left, 1 = serve right
//   state       out [2:0] current state (pong_pkg::state_e)
//   score_l/r   out [3:0] player scores
//   winner      out valid in OVER: 0 = left, 1 = right
// All outputs are registered; strobes appear the cycle after the deciding edge.
// -----------------------------------------------------------------------------
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int WIN_SCORE    = 7,
  parameter int SERVE_FRAMES = 60,
  parameter int KEY_START    = 0,
  parameter int KEY_PAUSE    = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                frame_tick,
  input  logic [4:0]          key_pulse,
  input  logic                hit_l,
  input  logic                hit_r,
  input  logic                miss_l,
  input  logic                miss_r,
  output logic                ball_step,
  output logic                ball_load,
  output logic                bounce_x,
  output logic                serve_dir,
  output logic [2:0]          state,
  output logic [SCORE_W-1:0]  score_l,
  output logic [SCORE_W-1:0]  score_r,
  output logic                winner
);

  localparam logic [SCORE_W-1:0] WIN_S   = SCORE_W'(WIN_SCORE);
  localparam logic [7:0]         SERVE_TC = 8'(SERVE_FRAMES - 1);

  state_e               r_state;
  state_e               w_state_nxt;
  logic                 r_ball_step, r_ball_load, r_bounce_x, r_serve_dir, r_winner;
  logic [SCORE_W-1:0]   r_score_l, r_score_r;
  logic                 w_ball_step_nxt, w_ball_load_nxt, w_bounce_nxt;
  logic                 w_serve_dir_nxt, w_winner_nxt;
  logic [SCORE_W-1:0]   w_score_l_nxt, w_score_r_nxt;
  logic                 w_key_start, w_key_pause, w_win, w_tc, w_cnt_clr;
  logic                 w_unused_keys;

  // START beats PAUSE when both arrive together.
  assign w_key_start   = key_pulse[KEY_START];
  assign w_key_pause   = key_pulse[KEY_PAUSE] & ~w_key_start;
  assign w_unused_keys = &{1'b0, key_pulse};
  assign w_win         = (r_score_l == WIN_S) | (r_score_r == WIN_S);

  // Counter only runs in SERVE; it is zeroed everywhere else and on release.
  assign w_cnt_clr = (r_state != ST_SERVE) | (frame_tick & w_tc);

  pong_frame_counter #(
    .TERMINAL (SERVE_TC)
  ) u_serve_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_cnt_clr),
    .i_en  (frame_tick),
    .o_tc  (w_tc)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_key_start) w_state_nxt = ST_SERVE;
      ST_SERVE: if (frame_tick && w_tc) w_state_nxt = ST_PLAY;
      ST_PLAY: begin
        // A pause arriving with frame_tick drops that frame entirely.
        if (w_key_pause)                w_state_nxt = ST_PAUSE;
        else if (frame_tick) begin
          if (miss_l && miss_r)         w_state_nxt = ST_SERVE;
          else if (miss_l || miss_r)    w_state_nxt = ST_POINT;
        end
      end
      ST_PAUSE: begin
        if (w_key_start)      w_state_nxt = ST_IDLE;
        else if (w_key_pause) w_state_nxt = ST_PLAY;
      end
      ST_POINT: w_state_nxt = w_win ? ST_OVER : ST_SERVE;
      ST_OVER:  if (w_key_start) w_state_nxt = ST_SERVE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Output logic (next values of the registered outputs)
  always_comb begin
    w_ball_step_nxt = 1'b0;
    w_ball_load_nxt = 1'b0;
    w_bounce_nxt    = 1'b0;
    w_serve_dir_nxt = r_serve_dir;
    w_score_l_nxt   = r_score_l;
    w_score_r_nxt   = r_score_r;
    w_winner_nxt    = r_winner;
    case (r_state)
      ST_IDLE: begin
        if (w_key_start) begin
          w_ball_load_nxt = 1'b1;
          w_score_l_nxt   = '0;
          w_score_r_nxt   = '0;
        end
      end
      ST_PLAY: begin
        if (!w_key_pause && frame_tick) begin
          if (miss_l && miss_r) begin
            w_ball_load_nxt = 1'b1;
          end else if (miss_l) begin
            w_score_r_nxt   = sat_inc(r_score_r, WIN_S);
            w_serve_dir_nxt = 1'b0;
          end else if (miss_r) begin
            w_score_l_nxt   = sat_inc(r_score_l, WIN_S);
            w_serve_dir_nxt = 1'b1;
          end else begin
            w_ball_step_nxt = 1'b1;
            w_bounce_nxt    = hit_l | hit_r;
          end
        end
      end
      ST_POINT: begin
        // serve_dir points at the loser, so the scorer is its complement.
        if (w_win) w_winner_nxt    = ~r_serve_dir;
        else       w_ball_load_nxt = 1'b1;
      end
      ST_OVER: begin
        if (w_key_start) begin
          w_ball_load_nxt = 1'b1;
          w_score_l_nxt   = '0;
          w_score_r_nxt   = '0;
          w_serve_dir_nxt = ~r_winner;
        end
      end
      default: ;
    endcase
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ball_step <= 1'b0;
      r_ball_load <= 1'b0;
      r_bounce_x  <= 1'b0;
      r_serve_dir <= 1'b1;
      r_score_l   <= '0;
      r_score_r   <= '0;
      r_winner    <= 1'b0;
    end else begin
      r_ball_step <= w_ball_step_nxt;
      r_ball_load <= w_ball_load_nxt;
      r_bounce_x  <= w_bounce_nxt;
      r_serve_dir <= w_serve_dir_nxt;
      r_score_l   <= w_score_l_nxt;
      r_score_r   <= w_score_r_nxt;
      r_winner    <= w_winner_nxt;
    end
  end

  assign ball_step = r_ball_step;
  assign ball_load = r_ball_load;
  assign bounce_x  = r_bounce_x;
  assign serve_dir = r_serve_dir;
  assign state     = r_state;
  assign score_l   = r_score_l;
  assign score_r   = r_score_r;
  assign winner    = r_winner;

endmodule

// File: tb/tb_pong_game_ctrl.sv
module tb_pong_game_ctrl;

  localparam int WIN = 7;
  localparam int SF  = 4;
  localparam logic [2:0] S_IDLE = 3'd0, S_SERVE = 3'd1, S_PLAY = 3'd2,
                         S_PAUSE = 3'd3, S_POINT = 3'd4, S_OVER = 3'd5;
  localparam logic [4:0] K_NONE = 5'b00000, K_START = 5'b00001, K_PAUSE = 5'b10000;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       frame_tick = 1'b0;
  logic [4:0] key_pulse = 5'd0;
  logic       hit_l = 1'b0, hit_r = 1'b0, miss_l = 1'b0, miss_r = 1'b0;
  logic       ball_step, ball_load, bounce_x, serve_dir, winner;
  logic [2:0] state;
  logic [3:0] score_l, score_r;

  always #5 clk = ~clk;

  pong_game_ctrl #(
    .WIN_SCORE    (WIN),
    .SERVE_FRAMES (SF),
    .KEY_START    (0),
    .KEY_PAUSE    (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (frame_tick),
    .key_pulse  (key_pulse),
    .hit_l      (hit_l),
    .hit_r      (hit_r),
    .miss_l     (miss_l),
    .miss_r     (miss_r),
    .ball_step  (ball_step),
    .ball_load  (ball_load),
    .bounce_x   (bounce_x),
    .serve_dir  (serve_dir),
    .state      (state),
    .score_l    (score_l),
    .score_r    (score_r),
    .winner     (winner)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: game rules as events, updated once per clock edge.
  logic [2:0] m_state = S_IDLE;
  logic [3:0] m_sl = 4'd0, m_sr = 4'd0;
  logic       m_dir = 1'b1, m_win = 1'b0;
  logic       m_step = 1'b0, m_load = 1'b0, m_bounce = 1'b0;
  int         m_frames = 0;

  task automatic mdl_edge(input logic r, input logic t, input logic [4:0] k,
                          input logic hl, input logic hr, input logic ml, input logic mr);
    logic st, pz;
    st = k[0];
    pz = k[4] && !k[0];
    m_step = 1'b0; m_load = 1'b0; m_bounce = 1'b0;
    if (!r) begin
      m_state = S_IDLE; m_sl = 0; m_sr = 0; m_dir = 1'b1; m_win = 1'b0; m_frames = 0;
    end else begin
      case (m_state)
        S_IDLE: if (st) begin
          m_state = S_SERVE; m_sl = 0; m_sr = 0; m_load = 1'b1; m_frames = 0;
        end
        S_SERVE: if (t) begin
          m_frames++;
          if (m_frames == SF) begin m_state = S_PLAY; m_frames = 0; end
        end
        S_PLAY: begin
          if (pz) m_state = S_PAUSE;
          else if (t) begin
            if (ml && mr) begin m_state = S_SERVE; m_load = 1'b1; m_frames = 0; end
            else if (ml) begin m_sr = m_sr + 1; m_dir = 1'b0; m_state = S_POINT; end
            else if (mr) begin m_sl = m_sl + 1; m_dir = 1'b1; m_state = S_POINT; end
            else begin m_step = 1'b1; m_bounce = hl || hr; end
          end
        end
        S_PAUSE: begin
          if (st) m_state = S_IDLE;
          else if (pz) m_state = S_PLAY;
        end
        S_POINT: begin
          if (m_sl == WIN || m_sr == WIN) begin
            m_state = S_OVER; m_win = (m_sr == WIN);
          end else begin
            m_state = S_SERVE; m_load = 1'b1; m_frames = 0;
          end
        end
        S_OVER: if (st) begin
          m_state = S_SERVE; m_sl = 0; m_sr = 0; m_load = 1'b1; m_dir = !m_win; m_frames = 0;
        end
        default: m_state = S_IDLE;
      endcase
    end
  endtask

  task automatic cyc(input logic r, input logic t, input logic [4:0] k,
                     input logic hl, input logic hr, input logic ml, input logic mr);
    rst = r; frame_tick = t; key_pulse = k;
    hit_l = hl; hit_r = hr; miss_l = ml; miss_r = mr;
    @(posedge clk);
    mdl_edge(r, t, k, hl, hr, ml, mr);
    #1;
  endtask

  task automatic idle();
    cyc(1, 0, K_NONE, 0, 0, 0, 0);
  endtask

  task automatic serve_out();
    repeat (SF) cyc(1, 1, K_NONE, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    repeat (3) cyc(0, 1, K_START, 1, 1, 1, 1);
    n_vec++;
    if ({state, score_l, score_r, ball_step, ball_load, bounce_x, serve_dir, winner} !==
        {S_IDLE, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL reset_state: got st=%0d sl=%0d sr=%0d stb=%b%b%b dir=%b win=%b, want st=0 sl=0 sr=0 stb=000 dir=1 win=0",
               state, score_l, score_r, ball_step, ball_load, bounce_x, serve_dir, winner);
    end
    idle();
    n_vec++;
    if (state !== S_IDLE) begin
      n_err++; $display("FAIL idle_hold: got st=%0d want %0d", state, S_IDLE);
    end
  endtask

  task automatic test_serve();
    cyc(1, 0, K_START, 0, 0, 0, 0);
    n_vec++;
    if ({state, ball_load, score_l, score_r} !== {S_SERVE, 1'b1, 4'd0, 4'd0}) begin
      n_err++; $display("FAIL start_load: got st=%0d load=%b want st=1 load=1", state, ball_load);
    end
    idle();
    n_vec++;
    if ({state, ball_load} !== {S_SERVE, 1'b0}) begin
      n_err++; $display("FAIL load_one_cycle: got st=%0d load=%b want st=1 load=0", state, ball_load);
    end
    repeat (SF - 1) cyc(1, 1, K_NONE, 0, 0, 0, 0);
    n_vec++;
    if ({state, ball_step} !== {S_SERVE, 1'b0}) begin
      n_err++; $display("FAIL serve_wait: got st=%0d step=%b want st=1 step=0", state, ball_step);
    end
    cyc(1, 1, K_NONE, 0, 0, 0, 0);
    n_vec++;
    if ({state, ball_step} !== {S_PLAY, 1'b0}) begin
      n_err++; $display("FAIL serve_release: got st=%0d step=%b want st=2 step=0", state, ball_step);
    end
    idle(); idle();
    n_vec++;
    if (ball_step !== 1'b0) begin
      n_err++; $display("FAIL step_without_tick: got %b want 0", ball_step);
    end
    cyc(1, 1, K_NONE, 0, 0, 0, 0);
    n_vec++;
    if ({ball_step, bounce_x} !== 2'b10) begin
      n_err++; $display("FAIL first_step: got step=%b bounce=%b want 1 0", ball_step, bounce_x);
    end
    idle();
    n_vec++;
    if (ball_step !== 1'b0) begin
      n_err++; $display("FAIL step_one_cycle: got %b want 0", ball_step);
    end
  endtask

  task automatic test_bounce();
    cyc(1, 1, K_NONE, 0, 1, 0, 0);
    n_vec++;
    if ({ball_step, bounce_x, score_l, score_r, state} !== {1'b1, 1'b1, 4'd0, 4'd0, S_PLAY}) begin
      n_err++; $display("FAIL bounce_r: got step=%b bounce=%b sl=%0d sr=%0d st=%0d want 1 1 0 0 2",
                        ball_step, bounce_x, score_l, score_r, state);
    end
    cyc(1, 0, K_NONE, 0, 1, 1, 0);
    n_vec++;
    if ({ball_step, bounce_x, state} !== {1'b0, 1'b0, S_PLAY}) begin
      n_err++; $display("FAIL off_tick_ignored: got step=%b bounce=%b st=%0d want 0 0 2",
                        ball_step, bounce_x, state);
    end
  endtask

  task automatic test_double_miss();
    cyc(1, 1, K_NONE, 0, 0, 1, 1);
    n_vec++;
    if ({state, ball_load, ball_step, score_l, score_r, serve_dir} !==
        {S_SERVE, 1'b1, 1'b0, 4'd0, 4'd0, 1'b1}) begin
      n_err++; $display("FAIL double_miss: got st=%0d load=%b step=%b sl=%0d sr=%0d dir=%b want 1 1 0 0 0 1",
                        state, ball_load, ball_step, score_l, score_r, serve_dir);
    end
    serve_out();
  endtask

  task automatic test_pause();
    cyc(1, 1, K_PAUSE, 0, 0, 0, 0);
    n_vec++;
    if ({state, ball_step} !== {S_PAUSE, 1'b0}) begin
      n_err++; $display("FAIL pause_drop_tick: got st=%0d step=%b want 3 0", state, ball_step);
    end
    for (int i = 0; i < 10; i++) begin
      cyc(1, 1, K_NONE, 1, 0, 1, 0);
      n_vec++;
      if ({state, ball_step, ball_load, bounce_x, score_r} !== {S_PAUSE, 3'b000, 4'd0}) begin
        n_err++; $display("FAIL paused_frame%0d: got st=%0d stb=%b%b%b sr=%0d want 3 000 0",
                          i, state, ball_step, ball_load, bounce_x, score_r);
      end
    end
    cyc(1, 0, K_PAUSE, 0, 0, 0, 0);
    n_vec++;
    if (state !== S_PLAY) begin
      n_err++; $display("FAIL resume: got st=%0d want 2", state);
    end
  endtask

  task automatic test_win();
    for (int i = 0; i < WIN - 1; i++) begin
      cyc(1, 1, K_NONE, 0, 0, 1, 0);
      idle();
      serve_out();
    end
    n_vec++;
    if ({state, score_l, score_r, serve_dir} !== {S_PLAY, 4'd0, 4'd6, 1'b0}) begin
      n_err++; $display("FAIL six_points: got st=%0d sl=%0d sr=%0d dir=%b want 2 0 6 0",
                        state, score_l, score_r, serve_dir);
    end
    cyc(1, 1, K_NONE, 0, 0, 1, 0);
    n_vec++;
    if ({state, score_r} !== {S_POINT, 4'd7}) begin
      n_err++; $display("FAIL winning_point: got st=%0d sr=%0d want 4 7", state, score_r);
    end
    idle();
    n_vec++;
    if ({state, winner, ball_load} !== {S_OVER, 1'b1, 1'b0}) begin
      n_err++; $display("FAIL game_over: got st=%0d win=%b load=%b want 5 1 0", state, winner, ball_load);
    end
    cyc(1, 1, K_PAUSE, 0, 0, 1, 0);
    n_vec++;
    if ({state, score_r, winner, ball_step} !== {S_OVER, 4'd7, 1'b1, 1'b0}) begin
      n_err++; $display("FAIL over_hold: got st=%0d sr=%0d win=%b step=%b want 5 7 1 0",
                        state, score_r, winner, ball_step);
    end
    cyc(1, 0, K_START, 0, 0, 0, 0);
    n_vec++;
    if ({state, score_l, score_r, serve_dir, ball_load} !== {S_SERVE, 4'd0, 4'd0, 1'b0, 1'b1}) begin
      n_err++; $display("FAIL restart: got st=%0d sl=%0d sr=%0d dir=%b load=%b want 1 0 0 0 1",
                        state, score_l, score_r, serve_dir, ball_load);
    end
  endtask

  task automatic test_reset_mid_play();
    serve_out();
    cyc(1, 1, K_NONE, 0, 0, 0, 1);
    idle();
    serve_out();
    n_vec++;
    if ({state, score_l, serve_dir} !== {S_PLAY, 4'd1, 1'b1}) begin
      n_err++; $display("FAIL pre_reset_play: got st=%0d sl=%0d dir=%b want 2 1 1", state, score_l, serve_dir);
    end
    repeat (3) cyc(0, 1, K_NONE, 1, 0, 0, 0);
    n_vec++;
    if ({state, score_l, score_r, ball_step, ball_load, bounce_x, serve_dir, winner} !==
        {S_IDLE, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}) begin
      n_err++; $display("FAIL reset_mid_play: got st=%0d sl=%0d sr=%0d stb=%b%b%b dir=%b win=%b want 0 0 0 000 1 0",
                        state, score_l, score_r, ball_step, ball_load, bounce_x, serve_dir, winner);
    end
    idle();
  endtask

  task automatic test_random();
    logic [15:0] got, exp;
    logic r, t, hl, hr, ml, mr;
    logic [4:0] k;
    for (int i = 0; i < 4000; i++) begin
      r  = ($urandom_range(0, 399) != 0);
      t  = ($urandom_range(0, 2) == 0);
      k  = K_NONE;
      if ($urandom_range(0, 29) == 0) k[0] = 1'b1;
      if ($urandom_range(0, 24) == 0) k[4] = 1'b1;
      if ($urandom_range(0, 9) == 0)  k[2] = 1'b1;
      hl = ($urandom_range(0, 3) == 0);
      hr = ($urandom_range(0, 3) == 0);
      ml = ($urandom_range(0, 6) == 0);
      mr = ($urandom_range(0, 6) == 0);
      cyc(r, t, k, hl, hr, ml, mr);
      got = {state, score_l, score_r, ball_step, ball_load, bounce_x, serve_dir, winner};
      exp = {m_state, m_sl, m_sr, m_step, m_load, m_bounce, m_dir, m_win};
      n_vec++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL random_cycle%0d: got {st,sl,sr,step,load,bounce,dir,win}=%h want %h", i, got, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_serve();
    test_bounce();
    test_double_miss();
    test_pause();
    test_win();
    test_reset_mid_play();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
